// File: rtl/mkio_pkg.sv
// Shared definitions for the MKIO bus-controller block.
//   state_e    : controller FSM states
//   Err*       : result codes reported on the error output
//   Cmd*/Sts*  : command and status word field positions
//   wc_decode  : word-count field to word count (0 encodes 32)
//   build_cmd  : packs the command word fields
package mkio_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StCmd,
      StWaitCmd,
      StData,
      StWaitData,
      StResp,
      StRxd,
      StFin
   } state_e;

   localparam logic [2:0] ErrOk     = 3'd0;
   localparam logic [2:0] ErrNoResp = 3'd1;
   localparam logic [2:0] ErrParity = 3'd2;
   localparam logic [2:0] ErrAddr   = 3'd3;
   localparam logic [2:0] ErrSync   = 3'd4;
   localparam logic [2:0] ErrShort  = 3'd5;
   localparam logic [2:0] ErrMsg    = 3'd6;

   localparam int unsigned CmdRtMsb     = 15;
   localparam int unsigned CmdRtLsb     = 11;
   localparam int unsigned CmdTrBit     = 10;
   localparam int unsigned CmdSaMsb     = 9;
   localparam int unsigned CmdSaLsb     = 5;
   localparam int unsigned CmdWcMsb     = 4;
   localparam int unsigned CmdWcLsb     = 0;
   localparam int unsigned StsMsgErrBit = 10;

   function automatic logic [5:0] wc_decode(input logic [4:0] wc);
      return (wc == 5'd0) ? 6'd32 : {1'b0, wc};
   endfunction

   function automatic logic [15:0] build_cmd(input logic [4:0] rt, input logic tr,
                                             input logic [4:0] sa, input logic [4:0] wc);
      logic [15:0] w;
      w = '0;
      w[CmdRtMsb:CmdRtLsb] = rt;
      w[CmdTrBit]          = tr;
      w[CmdSaMsb:CmdSaLsb] = sa;
      w[CmdWcMsb:CmdWcLsb] = wc;
      return w;
   endfunction

endpackage

// File: rtl/mkio_word_buffer.sv
// Word buffer with one write port and one registered read port.
//   clk_i   : clock
//   reset_i : synchronous active-high reset (clears the read register only)
//   we_i    : write strobe
//   waddr_i : write index
//   wdata_i : write data
//   raddr_i : read index
//   rdata_o : mem[raddr_i] one cycle after raddr_i
module mkio_word_buffer #(
   parameter int unsigned Depth = 32,
   parameter int unsigned Width = 16,
   parameter int unsigned AddrW = $clog2(Depth)
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             we_i,
   input  logic [AddrW-1:0] waddr_i,
   input  logic [Width-1:0] wdata_i,
   input  logic [AddrW-1:0] raddr_i,
   output logic [Width-1:0] rdata_o
);

   logic [Width-1:0] mem_q [Depth];
   logic [Width-1:0] rdata_q;

   // Storage is intentionally not reset.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/mkio_bc_control.sv
// MKIO bus-controller message sequencer.
// Sends a command word, then (BC->RT) the data words from the TX buffer, then waits for
// the RT status word; for RT->BC it then collects the returned data words into the RX
// buffer. Reports a result code and a one-cycle done pulse.
//   clk, reset            : fast clock, synchronous active-high reset
//   start, rt_addr, tr,
//   subaddr, word_count   : message request, latched when idle
//   wr_en/wr_addr/wr_data : host writes into the TX buffer (ignored while busy)
//   rd_addr/rd_data       : host reads from the RX buffer, one cycle latency
//   tx_ready/tx_data/
//   tx_cd/tx_busy         : handshake with the transmitter
//   rx_done/rx_data/
//   rx_cd/p_error         : received words from the receiver
//   busy/done/status/error: message state and result
module mkio_bc_control
   import mkio_pkg::*;
#(
   parameter int unsigned RESP_TIMEOUT = 448
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [4:0]  rt_addr,
   input  logic        tr,
   input  logic [4:0]  subaddr,
   input  logic [4:0]  word_count,
   input  logic        wr_en,
   input  logic [4:0]  wr_addr,
   input  logic [15:0] wr_data,
   input  logic [4:0]  rd_addr,
   output logic [15:0] rd_data,
   output logic        tx_ready,
   output logic [15:0] tx_data,
   output logic        tx_cd,
   input  logic        tx_busy,
   input  logic        rx_done,
   input  logic [15:0] rx_data,
   input  logic        rx_cd,
   input  logic        p_error,
   output logic        busy,
   output logic        done,
   output logic [15:0] status,
   output logic [2:0]  error
);

   localparam int unsigned TimerW = $clog2(RESP_TIMEOUT + 1);
   localparam logic [TimerW-1:0] TimerLast = TimerW'(RESP_TIMEOUT - 1);

   state_e            state_q;
   logic [4:0]        rt_q;
   logic              tr_q;
   logic [4:0]        sa_q;
   logic [4:0]        wc_q;
   logic [5:0]        n_words_q;
   logic [5:0]        idx_q;
   logic [TimerW-1:0] timer_q;
   logic              seen_busy_q;
   logic              tx_ready_q;
   logic [15:0]       tx_data_q;
   logic              tx_cd_q;
   logic              busy_q;
   logic              done_q;
   logic [15:0]       status_q;
   logic [2:0]        error_q;

   logic [15:0]       tx_buf_rdata;
   logic              tx_buf_we;
   logic              rx_buf_we;
   logic [2:0]        resp_err;
   logic [2:0]        rxd_err;

   assign tx_buf_we = wr_en & ~busy_q;

   // idx_q walks the TX buffer while sending and the RX buffer while receiving.
   mkio_word_buffer #(
      .Depth(32),
      .Width(16)
   ) u_tx_buf (
      .clk_i  (clk),
      .reset_i(reset),
      .we_i   (tx_buf_we),
      .waddr_i(wr_addr),
      .wdata_i(wr_data),
      .raddr_i(idx_q[4:0]),
      .rdata_o(tx_buf_rdata)
   );

   mkio_word_buffer #(
      .Depth(32),
      .Width(16)
   ) u_rx_buf (
      .clk_i  (clk),
      .reset_i(reset),
      .we_i   (rx_buf_we),
      .waddr_i(idx_q[4:0]),
      .wdata_i(rx_data),
      .raddr_i(rd_addr),
      .rdata_o(rd_data)
   );

   // Result of a word arriving in RESP / RXD; parity outranks sync outranks address.
   always_comb begin
      resp_err = ErrOk;
      if (p_error) begin
         resp_err = ErrParity;
      end else if (!rx_cd) begin
         resp_err = ErrSync;
      end else if (rx_data[CmdRtMsb:CmdRtLsb] != rt_q) begin
         resp_err = ErrAddr;
      end else if (tr_q && rx_data[StsMsgErrBit]) begin
         resp_err = ErrMsg;
      end
   end

   always_comb begin
      rxd_err = ErrOk;
      if (p_error) begin
         rxd_err = ErrParity;
      end else if (rx_cd) begin
         rxd_err = ErrSync;
      end
   end

   assign rx_buf_we = (state_q == StRxd) && rx_done && (rxd_err == ErrOk);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         rt_q        <= '0;
         tr_q        <= 1'b0;
         sa_q        <= '0;
         wc_q        <= '0;
         n_words_q   <= '0;
         idx_q       <= '0;
         timer_q     <= '0;
         seen_busy_q <= 1'b0;
         tx_ready_q  <= 1'b0;
         tx_data_q   <= '0;
         tx_cd_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         status_q    <= '0;
         error_q     <= ErrOk;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  rt_q      <= rt_addr;
                  tr_q      <= tr;
                  sa_q      <= subaddr;
                  wc_q      <= word_count;
                  n_words_q <= wc_decode(word_count);
                  idx_q     <= '0;
                  busy_q    <= 1'b1;
                  error_q   <= ErrOk;
                  state_q   <= StCmd;
               end
            end
            StCmd: begin
               tx_ready_q  <= 1'b1;
               tx_data_q   <= build_cmd(rt_q, tr_q, sa_q, wc_q);
               tx_cd_q     <= 1'b1;
               seen_busy_q <= 1'b0;
               state_q     <= StWaitCmd;
            end
            StWaitCmd: begin
               // Request stays up until the half-rate transmitter acknowledges it.
               if (!seen_busy_q) begin
                  if (tx_busy) begin
                     tx_ready_q  <= 1'b0;
                     seen_busy_q <= 1'b1;
                  end
               end else if (!tx_busy) begin
                  timer_q <= '0;
                  state_q <= tr_q ? StResp : StData;
               end
            end
            StData: begin
               tx_ready_q  <= 1'b1;
               tx_data_q   <= tx_buf_rdata;
               tx_cd_q     <= 1'b0;
               seen_busy_q <= 1'b0;
               state_q     <= StWaitData;
            end
            StWaitData: begin
               // Advancing idx on acknowledge gives the buffer read time to settle.
               if (!seen_busy_q) begin
                  if (tx_busy) begin
                     tx_ready_q  <= 1'b0;
                     seen_busy_q <= 1'b1;
                     idx_q       <= idx_q + 6'd1;
                  end
               end else if (!tx_busy) begin
                  if (idx_q == n_words_q) begin
                     timer_q <= '0;
                     state_q <= StResp;
                  end else begin
                     state_q <= StData;
                  end
               end
            end
            StResp: begin
               if (rx_done) begin
                  status_q <= rx_data;
                  if ((resp_err != ErrOk) || !tr_q) begin
                     error_q <= resp_err;
                     done_q  <= 1'b1;
                     state_q <= StFin;
                  end else begin
                     idx_q   <= '0;
                     timer_q <= '0;
                     state_q <= StRxd;
                  end
               end else if (timer_q == TimerLast) begin
                  error_q <= ErrNoResp;
                  done_q  <= 1'b1;
                  state_q <= StFin;
               end else begin
                  timer_q <= timer_q + 1'b1;
               end
            end
            StRxd: begin
               if (rx_done) begin
                  if (rxd_err != ErrOk) begin
                     error_q <= rxd_err;
                     done_q  <= 1'b1;
                     state_q <= StFin;
                  end else begin
                     timer_q <= '0;
                     idx_q   <= idx_q + 6'd1;
                     if ((idx_q + 6'd1) == n_words_q) begin
                        error_q <= ErrOk;
                        done_q  <= 1'b1;
                        state_q <= StFin;
                     end
                  end
               end else if (timer_q == TimerLast) begin
                  error_q <= ErrShort;
                  done_q  <= 1'b1;
                  state_q <= StFin;
               end else begin
                  timer_q <= timer_q + 1'b1;
               end
            end
            StFin: begin
               busy_q  <= 1'b0;
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign tx_ready = tx_ready_q;
   assign tx_data  = tx_data_q;
   assign tx_cd    = tx_cd_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign status   = status_q;
   assign error    = error_q;

endmodule

// File: tb/tb_mkio_bc_control.sv
// Bench for mkio_bc_control: directed scenarios plus randomized messages checked against
// a message-level model (command packing, response rules, expected buffer contents).
module tb_mkio_bc_control;

   localparam int RespTimeout = 448;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [4:0]  rt_addr;
   logic        tr;
   logic [4:0]  subaddr;
   logic [4:0]  word_count;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [15:0] wr_data;
   logic [4:0]  rd_addr;
   logic [15:0] rd_data;
   logic        tx_ready;
   logic [15:0] tx_data;
   logic        tx_cd;
   logic        tx_busy;
   logic        rx_done;
   logic [15:0] rx_data;
   logic        rx_cd;
   logic        p_error;
   logic        busy;
   logic        done;
   logic [15:0] status;
   logic [2:0]  error;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mkio_bc_control #(.RESP_TIMEOUT(RespTimeout)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .rt_addr   (rt_addr),
      .tr        (tr),
      .subaddr   (subaddr),
      .word_count(word_count),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .tx_ready  (tx_ready),
      .tx_data   (tx_data),
      .tx_cd     (tx_cd),
      .tx_busy   (tx_busy),
      .rx_done   (rx_done),
      .rx_data   (rx_data),
      .rx_cd     (rx_cd),
      .p_error   (p_error),
      .busy      (busy),
      .done      (done),
      .status    (status),
      .error     (error)
   );

   task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [15:0] model_cmd(int rt, int t, int sa, int wc);
      return 16'(rt * 2048 + t * 1024 + sa * 32 + wc);
   endfunction

   function automatic int model_count(int wc);
      return (wc == 0) ? 32 : wc;
   endfunction

   function automatic int model_status_err(bit perr, bit cd, int addr, int rt, bit t, bit me);
      if (perr) return 2;
      if (!cd) return 4;
      if (addr != rt) return 3;
      if (t && me) return 6;
      return 0;
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic host_write(input int a, input logic [15:0] d);
      @(negedge clk);
      wr_en   = 1'b1;
      wr_addr = 5'(a);
      wr_data = d;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic start_msg(input int rt, input bit t, input int sa, input int wc);
      @(negedge clk);
      start      = 1'b1;
      rt_addr    = 5'(rt);
      tr         = t;
      subaddr    = 5'(sa);
      word_count = 5'(wc);
      @(negedge clk);
      start = 1'b0;
      chk({31'd0, busy}, 32'd1, "busy_after_start");
   endtask

   // Transmitter model: acknowledge one request and check the word offered.
   task automatic tx_word(input logic [15:0] exp_w, input bit exp_cd, input bit echo,
                          input string tag);
      int n;
      bit seen;
      n = 0;
      seen = 1'b0;
      while (n < 64 && !seen) begin
         @(negedge clk);
         n++;
         seen = (tx_ready === 1'b1);
      end
      chk({31'd0, seen}, 32'd1, {tag, "_ready"});
      if (!seen) return;
      chk({16'd0, tx_data}, {16'd0, exp_w}, {tag, "_data"});
      chk({31'd0, tx_cd}, {31'd0, exp_cd}, {tag, "_cd"});
      repeat ($urandom_range(0, 3)) @(negedge clk);
      chk({15'd0, tx_ready, tx_cd, tx_data}, {15'd0, 1'b1, exp_cd, exp_w}, {tag, "_held"});
      tx_busy = 1'b1;
      @(negedge clk);
      chk({31'd0, tx_ready}, 32'd0, {tag, "_drop"});
      if (echo) begin
         rx_done = 1'b1;
         rx_data = exp_w;
         rx_cd   = exp_cd;
         p_error = 1'b0;
      end
      @(negedge clk);
      rx_done = 1'b0;
      repeat ($urandom_range(0, 4)) @(negedge clk);
      tx_busy = 1'b0;
   endtask

   task automatic rx_word(input logic [15:0] w, input bit cd, input bit perr);
      @(negedge clk);
      rx_done = 1'b1;
      rx_data = w;
      rx_cd   = cd;
      p_error = perr;
      @(negedge clk);
      rx_done = 1'b0;
      p_error = 1'b0;
   endtask

   task automatic finish_msg(input int exp_err, input logic [15:0] exp_sts, input string tag);
      int cyc;
      cyc = 0;
      while (done !== 1'b1 && cyc < 64) begin
         @(negedge clk);
         cyc++;
      end
      chk({31'd0, done}, 32'd1, {tag, "_done"});
      chk({29'd0, error}, 32'(exp_err), {tag, "_error"});
      chk({16'd0, status}, {16'd0, exp_sts}, {tag, "_status"});
      @(negedge clk);
      chk({30'd0, done, busy}, 32'd0, {tag, "_done_busy_clear"});
   endtask

   task automatic read_chk(input int a, input logic [15:0] exp, input string tag);
      @(negedge clk);
      rd_addr = 5'(a);
      @(negedge clk);
      chk({16'd0, rd_data}, {16'd0, exp}, tag);
   endtask

   // kind: 0 ok, 1 bad address, 2 status parity, 3 status wrong sync,
   //       4 RT message error, 5 data parity, 6 data wrong sync
   task automatic run_msg(input int rt, input bit t, input int sa, input int wc, input int kind);
      int n, e, k, addr, got;
      bit me, perr, cd;
      logic [15:0] txw [32];
      logic [15:0] rxw [32];
      logic [15:0] sts;
      logic [15:0] w;
      n = model_count(wc);
      if (!t) begin
         for (int i = 0; i < n; i++) begin
            txw[i] = 16'($urandom);
            host_write(i, txw[i]);
         end
      end
      start_msg(rt, t, sa, wc);
      tx_word(model_cmd(rt, int'(t), sa, wc), 1'b1, 1'($urandom_range(0, 1)), "cmd");
      if (!t) begin
         for (int i = 0; i < n; i++) tx_word(txw[i], 1'b0, 1'($urandom_range(0, 1)), "data");
      end
      addr = (kind == 1) ? (rt ^ $urandom_range(1, 31)) : rt;
      me   = (kind == 4) ? 1'b1 : (t ? 1'b0 : 1'($urandom_range(0, 1)));
      perr = (kind == 2);
      cd   = (kind != 3);
      sts  = 16'(addr * 2048 + int'(me) * 1024 + $urandom_range(0, 1023));
      repeat ($urandom_range(0, 5)) @(negedge clk);
      rx_word(sts, cd, perr);
      e = model_status_err(perr, cd, addr, rt, t, me);
      got = 0;
      if (e == 0 && t) begin
         k = $urandom_range(0, n - 1);
         for (int j = 0; j < n; j++) begin
            w = 16'($urandom);
            if ((kind == 5 || kind == 6) && j == k) begin
               rx_word(w, kind == 6, kind == 5);
               e = (kind == 5) ? 2 : 4;
               break;
            end
            rx_word(w, 1'b0, 1'b0);
            rxw[j] = w;
            got++;
         end
      end
      finish_msg(e, sts, "msg");
      for (int j = 0; j < got; j++) read_chk(j, rxw[j], "rx_buf");
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int cyc, kind, t, wc;
      bit saw_done, seen;
      reset = 1'b1; start = 1'b0; rt_addr = '0; tr = 1'b0; subaddr = '0; word_count = '0;
      wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0; tx_busy = 1'b0;
      rx_done = 1'b0; rx_data = '0; rx_cd = 1'b0; p_error = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk({31'd0, tx_ready}, 32'd0, "rst_tx_ready");
      chk({16'd0, tx_data}, 32'd0, "rst_tx_data");
      chk({31'd0, tx_cd}, 32'd0, "rst_tx_cd");
      chk({31'd0, busy}, 32'd0, "rst_busy");
      chk({31'd0, done}, 32'd0, "rst_done");
      chk({16'd0, status}, 32'd0, "rst_status");
      chk({29'd0, error}, 32'd0, "rst_error");
      chk({16'd0, rd_data}, 32'd0, "rst_rd_data");

      // BC->RT rt=3 sa=1 wc=2; a host write during the message must be ignored.
      host_write(0, 16'h1234);
      host_write(1, 16'hABCD);
      start_msg(3, 1'b0, 1, 2);
      host_write(1, 16'hDEAD);
      tx_word(16'h1822, 1'b1, 1'b1, "d1_cmd");
      tx_word(16'h1234, 1'b0, 1'b0, "d1_w0");
      tx_word(16'hABCD, 1'b0, 1'b1, "d1_w1");
      rx_word(16'h1800, 1'b1, 1'b0);
      finish_msg(0, 16'h1800, "d1");

      // RT->BC rt=5 sa=2 wc=3.
      start_msg(5, 1'b1, 2, 3);
      tx_word(16'h2C43, 1'b1, 1'b0, "d2_cmd");
      rx_word(16'h2800, 1'b1, 1'b0);
      rx_word(16'h0001, 1'b0, 1'b0);
      rx_word(16'h0002, 1'b0, 1'b0);
      rx_word(16'h0003, 1'b0, 1'b0);
      finish_msg(0, 16'h2800, "d2");
      read_chk(0, 16'h0001, "d2_buf0");
      read_chk(1, 16'h0002, "d2_buf1");
      read_chk(2, 16'h0003, "d2_buf2");

      // No response after a one-word BC->RT message.
      host_write(0, 16'h5A5A);
      start_msg(7, 1'b0, 4, 1);
      tx_word(model_cmd(7, 0, 4, 1), 1'b1, 1'b0, "to_cmd");
      tx_word(16'h5A5A, 1'b0, 1'b0, "to_w0");
      cyc = 0;
      while (done !== 1'b1 && cyc < RespTimeout + 50) begin
         @(negedge clk);
         cyc++;
      end
      chk(32'(cyc), 32'(RespTimeout + 1), "timeout_latency");
      chk({29'd0, error}, 32'd1, "timeout_error");

      // Address mismatch.
      host_write(0, 16'h0F0F);
      start_msg(3, 1'b0, 1, 1);
      tx_word(model_cmd(3, 0, 1, 1), 1'b1, 1'b0, "am_cmd");
      tx_word(16'h0F0F, 1'b0, 1'b0, "am_w0");
      rx_word(16'h1000, 1'b1, 1'b0);
      finish_msg(3, 16'h1000, "addr_mismatch");

      // Parity error on the second RT->BC data word.
      start_msg(5, 1'b1, 2, 3);
      tx_word(16'h2C43, 1'b1, 1'b0, "pe_cmd");
      rx_word(16'h2800, 1'b1, 1'b0);
      rx_word(16'h0A0A, 1'b0, 1'b0);
      rx_word(16'h0B0B, 1'b0, 1'b1);
      finish_msg(2, 16'h2800, "data_parity");
      read_chk(0, 16'h0A0A, "pe_buf0");

      // wc=0 means 32 words.
      run_msg($urandom_range(0, 31), 1'b0, $urandom_range(0, 31), 0, 0);

      // Reset during the 5th data word.
      for (int i = 0; i < 8; i++) host_write(i, 16'(16'h4000 + i));
      start_msg(9, 1'b0, 3, 8);
      tx_word(model_cmd(9, 0, 3, 8), 1'b1, 1'b0, "rs_cmd");
      for (int i = 0; i < 4; i++) tx_word(16'(16'h4000 + i), 1'b0, 1'b0, "rs_data");
      cyc = 0;
      seen = 1'b0;
      while (cyc < 64 && !seen) begin
         @(negedge clk);
         cyc++;
         seen = (tx_ready === 1'b1);
      end
      chk({31'd0, seen}, 32'd1, "rs_5th_ready");
      reset = 1'b1;
      @(negedge clk);
      chk({30'd0, tx_ready, busy}, 32'd0, "rs_ready_busy");
      reset = 1'b0;
      saw_done = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (done === 1'b1) saw_done = 1'b1;
      end
      chk({31'd0, saw_done}, 32'd0, "rs_no_done");
      run_msg($urandom_range(0, 31), 1'b0, $urandom_range(0, 31), 1, 0);

      // Randomized messages.
      for (int it = 0; it < 14; it++) begin
         t    = $urandom_range(0, 1);
         wc   = (it % 5 == 4) ? 0 : $urandom_range(1, 6);
         kind = (t != 0) ? $urandom_range(0, 6) : $urandom_range(0, 3);
         run_msg($urandom_range(0, 31), t[0], $urandom_range(0, 31), wc, kind);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
